vga_timing_gen: RTL

//  Raster timing source for the VGA path. Divides clk_in down to a pixel tick and runs the

---
 rtl/vga_timing_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
//   Raster timing source for the VGA path. Divides clk_in down to one pixel
//   tick every CLK_DIV clocks and steps the horizontal/vertical counters.
//   Produces the current_row/current_line/enable triple for the colour stage
//   plus the monitor sync pulses. Default timing is 640x480@60 from 100 MHz.
//
// Ports
//   clk_in          in   system clock
//   rst_n_in        in   asynchronous reset, active-low
//   run_in          in   1 = generate raster, 0 = park at (0,0) blanked
//   current_row     out  horizontal pixel index
//   current_line    out  vertical line index
//   enable          out  high while inside the visible area
//   hsync_out       out  horizontal sync, active level SYNC_POL
//   vsync_out       out  vertical sync, active level SYNC_POL
//   pix_tick_out    out  one-clk pulse per pixel period
//   frame_start_out out  one-clk pulse when the raster wraps to (0,0)
//
// Configuration
//   VGA_SYNC_ALIGN_EN  when defined, hsync_out/vsync_out get one extra clk_in
//                      register to line up with the registered colour stage.
//
// Handshake: none. run_in is a level; it is sampled on every clk_in edge.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       run_in,
    output logic [9:0] current_row,
    output logic [9:0] current_line,
    output logic       enable,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       pix_tick_out,
    output logic       frame_start_out
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             enable_q, enable_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick_q, tick_d;
    logic             fs_q, fs_d;
    logic             step;
    logic             running_d;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: run_in alone decides, at any raster position.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run_in)  state_d = ST_RUN;
            ST_RUN:  if (!run_in) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of every registered output. Counters only
    // advance while staying in RUN, so the entry clock (IDLE->RUN) starts the
    // divider from 0 and the first (0,0) is held CLK_DIV clocks from there.
    always_comb begin
        running_d = (state_d == ST_RUN);
        step      = 1'b0;
        div_d     = '0;
        h_d       = '0;
        v_d       = '0;
        if (state_q == ST_RUN && running_d) begin
            step  = (div_q == DIV_LAST);
            div_d = step ? '0 : div_q + DIV_W'(1);
            h_d   = h_q;
            v_d   = v_q;
            if (step) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
        end
        // Decoded from the next counts so every output register flips on the
        // same edge as the counters it describes.
        enable_d = running_d && (h_d < H_ACT) && (v_d < V_ACT);
        hsync_d  = (running_d && h_d >= HS_START && h_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = (running_d && v_d >= VS_START && v_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
        tick_d   = running_d && (div_d == DIV_LAST);
        // Only a wrap sets this; IDLE->RUN entry has step=0.
        fs_d     = step && (h_d == 10'd0) && (v_d == 10'd0);
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            enable_q <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            tick_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            enable_q <= enable_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            tick_q   <= tick_d;
            fs_q     <= fs_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // One extra stage so syncs match the colour stage's registered latency.
    logic hsync_dly_q, vsync_dly_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hsync_dly_q <= ~SYNC_POL;
            vsync_dly_q <= ~SYNC_POL;
        end else begin
            hsync_dly_q <= hsync_q;
            vsync_dly_q <= vsync_q;
        end
    end

    assign hsync_out = hsync_dly_q;
    assign vsync_out = vsync_dly_q;
`else
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
`endif

    assign current_row     = h_q;
    assign current_line    = v_q;
    assign enable          = enable_q;
    assign pix_tick_out    = tick_q;
    assign frame_start_out = fs_q;

endmodule
